// File: rtl/program_sequencer_if.sv
// Flow-control bus between the Nibbler microcode decoder/ROM and the program sequencer.
interface program_sequencer_if #(
  parameter int ADDR_W      = 12,
  parameter int OP_W        = 8,
  parameter int STACK_DEPTH = 4
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  logic              enable;
  logic [OP_W-1:0]   opcode;
  logic [2:0]        flow_op;
  logic              cond;
  logic [ADDR_W-1:0] target;

  logic [ADDR_W-1:0] pc;
  logic [OP_W-1:0]   instr;
  logic              phase;
  logic              halted;
  logic [SP_W-1:0]   sp;
  logic              overflow;
  logic              underflow;

  modport master (
    output enable, opcode, flow_op, cond, target,
    input  pc, instr, phase, halted, sp, overflow, underflow
  );

  modport slave (
    input  enable, opcode, flow_op, cond, target,
    output pc, instr, phase, halted, sp, overflow, underflow
  );
endinterface

// File: rtl/program_sequencer.sv
// Nibbler program-flow unit: PC, fetch register, fetch/execute phase, call/return stack and halt.
module program_sequencer #(
  parameter int                ADDR_W      = 12,
  parameter int                OP_W        = 8,
  parameter int                STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
  parameter bit                PC_WRAP     = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  program_sequencer_if.slave bus
);
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  typedef enum logic {
    PH_FETCH = 1'b0,
    PH_EXEC  = 1'b1
  } phase_t;

  typedef enum logic [2:0] {
    FL_NEXT    = 3'd0,
    FL_JUMP    = 3'd1,
    FL_JUMP_IF = 3'd2,
    FL_CALL    = 3'd3,
    FL_RET     = 3'd4,
    FL_HALT    = 3'd5
  } flow_t;

  phase_t            phase_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_inc;
  logic [OP_W-1:0]   instr_q;
  logic              halted_q;
  logic [SP_W-1:0]   sp_q;
  logic              ovf_q;
  logic              unf_q;
  logic [IDX_W-1:0]  push_idx;
  logic [IDX_W-1:0]  pop_idx;
  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

  // End of range: saturate at all-ones unless wrapping is selected.
  always_comb begin
    pc_inc = pc_q + ADDR_W'(1);
    if (!PC_WRAP && (pc_q == '1)) begin
      pc_inc = pc_q;
    end
  end

  assign push_idx = IDX_W'(sp_q);
  assign pop_idx  = IDX_W'(sp_q - SP_W'(1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q     <= RESET_ADDR;
      instr_q  <= '0;
      phase_q  <= PH_FETCH;
      halted_q <= 1'b0;
      sp_q     <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else if (bus.enable && !halted_q) begin
      unique case (phase_q)
        PH_FETCH: begin
          instr_q <= bus.opcode;
          pc_q    <= pc_inc;
          phase_q <= PH_EXEC;
        end
        PH_EXEC: begin
          phase_q <= PH_FETCH;
          // pc already points past the instruction, so it is the return address.
          case (bus.flow_op)
            FL_JUMP: pc_q <= bus.target;
            FL_JUMP_IF: begin
              if (bus.cond) begin
                pc_q <= bus.target;
              end
            end
            FL_CALL: begin
              if (sp_q < SP_FULL) begin
                stack_mem[push_idx] <= pc_q;
                sp_q                <= sp_q + SP_W'(1);
                pc_q                <= bus.target;
              end else begin
                ovf_q <= 1'b1;
              end
            end
            FL_RET: begin
              if (sp_q != '0) begin
                pc_q <= stack_mem[pop_idx];
                sp_q <= sp_q - SP_W'(1);
              end else begin
                unf_q <= 1'b1;
              end
            end
            FL_HALT: halted_q <= 1'b1;
            default: ;
          endcase
        end
        default: phase_q <= PH_FETCH;
      endcase
    end
  end

  assign bus.pc        = pc_q;
  assign bus.instr     = instr_q;
  assign bus.phase     = phase_q;
  assign bus.halted    = halted_q;
  assign bus.sp        = sp_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench: three sequencers (12-bit saturating, 4-bit saturating, 4-bit wrapping) vs a behavioural model.
module tb_program_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  program_sequencer_if #(.ADDR_W(12)) bus0();
  program_sequencer_if #(.ADDR_W(4))  bus1();
  program_sequencer_if #(.ADDR_W(4))  bus2();

  program_sequencer #(.ADDR_W(12)) dut0 (.clock(clock), .reset(reset), .bus(bus0.slave));
  program_sequencer #(.ADDR_W(4), .PC_WRAP(1'b0)) dut1 (.clock(clock), .reset(reset), .bus(bus1.slave));
  program_sequencer #(.ADDR_W(4), .PC_WRAP(1'b1)) dut2 (.clock(clock), .reset(reset), .bus(bus2.slave));

  function automatic logic [7:0] rom(input int a);
    return 8'((a * 37 + 11) ^ (a >> 4));
  endfunction

  assign bus0.opcode = rom(int'(bus0.pc));
  assign bus1.opcode = rom(int'(bus1.pc));
  assign bus2.opcode = rom(int'(bus2.pc));

  typedef struct packed {
    logic [11:0] pc;
    logic [7:0]  instr;
    logic        phase;
    logic        halted;
    logic [2:0]  sp;
    logic        ovf;
    logic        unf;
  } snap_t;
  typedef snap_t [2:0] snap3_t;

  snap3_t exp_q[$];
  int errors = 0;
  int checks = 0;

  // Behavioural model: one entry per DUT, stack as a plain array with a count.
  int m_pc[3], m_instr[3], m_sp[3];
  int m_stk[3][4];
  bit m_ph[3], m_halt[3], m_ovf[3], m_unf[3];
  int mask[3] = '{4095, 15, 15};
  bit wrapk[3] = '{1'b0, 1'b0, 1'b1};

  task automatic model_edge(input int k, input bit rst, input bit en, input int op, input bit c, input int tgt);
    if (!rst) begin
      m_pc[k] = 0; m_instr[k] = 0; m_ph[k] = 0; m_halt[k] = 0;
      m_sp[k] = 0; m_ovf[k] = 0; m_unf[k] = 0;
    end else if (en && !m_halt[k]) begin
      if (!m_ph[k]) begin
        m_instr[k] = int'(rom(m_pc[k]));
        if (m_pc[k] == mask[k]) m_pc[k] = wrapk[k] ? 0 : mask[k];
        else m_pc[k] = m_pc[k] + 1;
        m_ph[k] = 1;
      end else begin
        m_ph[k] = 0;
        if (op == 1 || (op == 2 && c)) m_pc[k] = tgt & mask[k];
        else if (op == 3) begin
          if (m_sp[k] < 4) begin
            m_stk[k][m_sp[k]] = m_pc[k];
            m_sp[k] = m_sp[k] + 1;
            m_pc[k] = tgt & mask[k];
          end else m_ovf[k] = 1;
        end else if (op == 4) begin
          if (m_sp[k] > 0) begin
            m_sp[k] = m_sp[k] - 1;
            m_pc[k] = m_stk[k][m_sp[k]];
          end else m_unf[k] = 1;
        end else if (op == 5) m_halt[k] = 1;
      end
    end
  endtask

  task automatic step(input bit rst, input bit en, input logic [2:0] op, input bit c, input logic [11:0] tgt);
    snap3_t e;
    @(negedge clock);
    reset = rst;
    bus0.enable = en;  bus1.enable = en;  bus2.enable = en;
    bus0.flow_op = op; bus1.flow_op = op; bus2.flow_op = op;
    bus0.cond = c;     bus1.cond = c;     bus2.cond = c;
    bus0.target = tgt; bus1.target = tgt[3:0]; bus2.target = tgt[3:0];
    for (int k = 0; k < 3; k++) begin
      model_edge(k, rst, en, int'(op), c, int'(tgt));
      e[k].pc     = 12'(m_pc[k]);
      e[k].instr  = 8'(m_instr[k]);
      e[k].phase  = m_ph[k];
      e[k].halted = m_halt[k];
      e[k].sp     = 3'(m_sp[k]);
      e[k].ovf    = m_ovf[k];
      e[k].unf    = m_unf[k];
    end
    exp_q.push_back(e);
  endtask

  // One full instruction: fetch with junk flow inputs, then execute the given command.
  task automatic instr(input logic [2:0] op, input bit c, input logic [11:0] tgt);
    step(1'b1, 1'b1, 3'($urandom_range(0, 7)), 1'($urandom), 12'($urandom));
    step(1'b1, 1'b1, op, c, tgt);
  endtask

  task automatic chk(input string nm, input int k, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, a, e, $time);
    end
  endtask

  initial begin
    snap3_t e;
    snap3_t act;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act[0] = {bus0.pc, bus0.instr, bus0.phase, bus0.halted, bus0.sp, bus0.overflow, bus0.underflow};
        act[1] = {8'h0, bus1.pc, bus1.instr, bus1.phase, bus1.halted, bus1.sp, bus1.overflow, bus1.underflow};
        act[2] = {8'h0, bus2.pc, bus2.instr, bus2.phase, bus2.halted, bus2.sp, bus2.overflow, bus2.underflow};
        for (int k = 0; k < 3; k++) begin
          chk("pc",        k, 32'(act[k].pc),     32'(e[k].pc));
          chk("instr",     k, 32'(act[k].instr),  32'(e[k].instr));
          chk("phase",     k, 32'(act[k].phase),  32'(e[k].phase));
          chk("halted",    k, 32'(act[k].halted), 32'(e[k].halted));
          chk("sp",        k, 32'(act[k].sp),     32'(e[k].sp));
          chk("overflow",  k, 32'(act[k].ovf),    32'(e[k].ovf));
          chk("underflow", k, 32'(act[k].unf),    32'(e[k].unf));
        end
      end
    end
  end

  initial begin
    logic [2:0] op;
    bus0.enable = 1'b0; bus1.enable = 1'b0; bus2.enable = 1'b0;

    // Reset then straight-line fetch/execute
    step(1'b0, 1'b1, 3'd0, 1'b0, 12'h0);
    step(1'b0, 1'b1, 3'd0, 1'b0, 12'h0);
    repeat (8) step(1'b1, 1'b1, 3'd0, 1'b0, 12'h0);

    // Branching from pc=5
    instr(3'd1, 1'b0, 12'h123);
    instr(3'd2, 1'b0, 12'h010);
    instr(3'd2, 1'b1, 12'h010);

    // Call/return from pc=3, then stack overflow/underflow
    instr(3'd1, 1'b0, 12'h002);
    instr(3'd3, 1'b0, 12'h100);
    instr(3'd4, 1'b0, 12'h000);
    repeat (5) instr(3'd3, 1'b0, 12'($urandom));
    repeat (5) instr(3'd4, 1'b0, 12'($urandom));

    // End of range: saturate vs wrap
    instr(3'd1, 1'b0, 12'hFFF);
    instr(3'd0, 1'b0, 12'h000);
    instr(3'd0, 1'b0, 12'h000);

    // Stall mid-execute
    step(1'b1, 1'b1, 3'd0, 1'b0, 12'h0);
    repeat (3) step(1'b1, 1'b0, 3'($urandom_range(0, 7)), 1'($urandom), 12'($urandom));
    step(1'b1, 1'b1, 3'd0, 1'b0, 12'h0);

    // Reset during execute of a CALL with sp=2
    instr(3'd3, 1'b0, 12'h200);
    instr(3'd3, 1'b0, 12'h300);
    step(1'b1, 1'b1, 3'd0, 1'b0, 12'h0);
    step(1'b0, 1'b1, 3'd3, 1'b0, 12'h400);
    instr(3'd0, 1'b0, 12'h000);

    // Randomized traffic with stalls, rare halts and occasional resets
    for (int i = 0; i < 400; i++) begin
      op = 3'($urandom_range(0, 7));
      if (op == 3'd5 && $urandom_range(0, 9) != 0) op = 3'd0;
      step(($urandom_range(0, 99) >= 3), ($urandom_range(0, 9) != 0), op, 1'($urandom), 12'($urandom));
    end

    // Halt then ten enabled cycles
    step(1'b0, 1'b1, 3'd0, 1'b0, 12'h0);
    instr(3'd5, 1'b0, 12'h000);
    repeat (10) step(1'b1, 1'b1, 3'($urandom_range(0, 7)), 1'($urandom), 12'($urandom));

    repeat (3) @(posedge clock);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
